// File: rtl/cla_pipelined_adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_pipelined_adder_pkg;

   // Width of one lookahead block; slices are built from these rippled together.
   localparam int unsigned CLA_BLK = 4;

   // ALU op encoding on the sub input.
   localparam logic ADD = 1'b0;
   localparam logic SUB = 1'b1;

   // Legal configuration: at least one stage and every stage a whole number of blocks.
   function automatic logic slicing_ok(input int unsigned width, input int unsigned stages);
      return (stages != 0) && ((width % (CLA_BLK * stages)) == 0);
   endfunction

endpackage

// File: rtl/cla_pipelined_adder_cla_4_bit.sv
// Combinational 4-bit carry-lookahead block with group propagate/generate.
module cla_4_bit
   import cla_pipelined_adder_pkg::*;
(
   input  logic [CLA_BLK-1:0] a,
   input  logic [CLA_BLK-1:0] b,
   input  logic               c_in,
   output logic [CLA_BLK-1:0] sum,
   output logic               c_out,
   output logic               p,
   output logic               g
);

   logic [CLA_BLK-1:0] pp;
   logic [CLA_BLK-1:0] gg;
   logic [CLA_BLK-1:0] c;

   // Bit propagate/generate, flattened lookahead carries, group terms.
   always_comb begin
      pp    = a ^ b;
      gg    = a & b;
      c[0]  = c_in;
      c[1]  = gg[0] | (pp[0] & c_in);
      c[2]  = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c_in);
      c[3]  = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
            | (pp[2] & pp[1] & pp[0] & c_in);
      g     = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
            | (pp[3] & pp[2] & pp[1] & gg[0]);
      p     = &pp;
      c_out = g | (p & c_in);
      sum   = pp ^ c;
   end

endmodule

// File: rtl/cla_pipelined_adder.sv
// Pipelined CLA adder/subtractor: one slice of the operands is added per
// clock, with the slice carry and the not-yet-added operand bits registered
// between stages. A single advance enable stalls the whole pipe together.
module cla_pipelined_adder
   import cla_pipelined_adder_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int unsigned SW = WIDTH / STAGES;
   localparam int unsigned NB = SW / CLA_BLK;

   if (!slicing_ok(WIDTH, STAGES)) begin : g_bad_cfg
      $error("cla_pipelined_adder: WIDTH must be a multiple of 4*STAGES");
   end

   // Stage registers: valid, operands (b already inverted for sub), partial sum, slice carry.
   logic             v_q [STAGES];
   logic [WIDTH-1:0] a_q [STAGES];
   logic [WIDTH-1:0] b_q [STAGES];
   logic [WIDTH-1:0] s_q [STAGES];
   logic             c_q [STAGES];
   logic             ovf_q;

   // Next-state values produced by each stage's adder slice.
   logic [WIDTH-1:0] a_nxt [STAGES];
   logic [WIDTH-1:0] b_nxt [STAGES];
   logic [WIDTH-1:0] s_nxt [STAGES];
   logic             c_nxt [STAGES];
   logic             ovf_nxt;

   logic adv;

   // Whole pipe moves when the output slot is empty or being drained.
   always_comb begin
      adv = !v_q[STAGES-1] || out_ready;
   end

   assign in_ready  = adv;
   assign out_valid = v_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign c_out     = c_q[STAGES-1];
   assign ovf       = ovf_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] op_a;
      logic [WIDTH-1:0] op_b;
      logic [WIDTH-1:0] part;
      logic [WIDTH-1:0] s_n;
      logic             cin;
      logic [SW-1:0]    sl_sum;
      logic [NB:0]      cy;
      logic [NB-1:0]    blk_p;
      logic [NB-1:0]    blk_g;
      logic             la_g;
      logic             la_p;
      logic             la_c;

      if (k == 0) begin : g_head
         // First stage works straight off the input beat; b is conditioned here.
         assign op_a = a;
         assign op_b = (sub == SUB) ? ~b : b;
         assign part = '0;
         assign cin  = (sub == ADD) ? c_in : 1'b1;
      end else begin : g_body
         assign op_a = a_q[k-1];
         assign op_b = b_q[k-1];
         assign part = s_q[k-1];
         assign cin  = c_q[k-1];
      end

      assign cy[0] = cin;

      for (genvar j = 0; j < NB; j++) begin : g_blk
         cla_4_bit u_cla (
            .a     (op_a[k*SW + j*CLA_BLK +: CLA_BLK]),
            .b     (op_b[k*SW + j*CLA_BLK +: CLA_BLK]),
            .c_in  (cy[j]),
            .sum   (sl_sum[j*CLA_BLK +: CLA_BLK]),
            .c_out (cy[j+1]),
            .p     (blk_p[j]),
            .g     (blk_g[j])
         );
      end

      // Merge this slice's result into the beat's partial sum.
      always_comb begin
         s_n              = part;
         s_n[k*SW +: SW]  = sl_sum;
      end

      // Slice carry recomputed from the group P/G terms for cross-checking the ripple.
      always_comb begin
         la_g = 1'b0;
         la_p = 1'b1;
         for (int j = 0; j < NB; j++) begin
            la_g = blk_g[j] | (blk_p[j] & la_g);
            la_p = la_p & blk_p[j];
         end
         la_c = la_g | (la_p & cin);
      end

      // Rippled block carry must agree with the group lookahead carry.
      always_ff @(posedge clk) begin
         if (!rst) begin
            assert (la_c == cy[NB]);
         end
      end

      assign a_nxt[k] = op_a;
      assign b_nxt[k] = op_b;
      assign s_nxt[k] = s_n;
      assign c_nxt[k] = cy[NB];

      if (k == STAGES - 1) begin : g_tail
         logic c_msb;
         // Carry into the MSB recovered from the MSB sum bit and its operands.
         assign c_msb   = sl_sum[SW-1] ^ op_a[WIDTH-1] ^ op_b[WIDTH-1];
         assign ovf_nxt = c_msb ^ cy[NB];
      end
   end

   // Stage register bank: clear on reset, shift together when advancing.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            v_q[k] <= 1'b0;
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
            c_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else if (adv) begin
         v_q[0] <= in_valid;
         for (int k = 1; k < STAGES; k++) begin
            v_q[k] <= v_q[k-1];
         end
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_nxt[k];
            b_q[k] <= b_nxt[k];
            s_q[k] <= s_nxt[k];
            c_q[k] <= c_nxt[k];
         end
         ovf_q <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_cla_pipelined_adder.sv
// Self-checking bench for cla_pipelined_adder (16-bit / 4 stages, plus 8/1 and 32/2 builds).
module tb_cla_pipelined_adder;

   localparam int unsigned W = 16;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } res_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      res_t         exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         c_out;
   logic         ovf;

   // Secondary builds for parametrisation.
   logic         p_valid;
   logic         p_ready;
   logic         p_sub;
   logic         p_cin;
   logic [7:0]   a8, b8, sum8;
   logic         ir8, ov8, co8, of8;
   logic [31:0]  a32, b32, sum32;
   logic         ir32, ov32, co32, of32;

   int   tests = 0;
   int   fails = 0;
   res_t exp_q[$];
   vec_t vec[10];

   always #5 clk = ~clk;

   cla_pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .c_in(c_in), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .c_out(c_out), .ovf(ovf)
   );

   cla_pipelined_adder #(.WIDTH(8), .STAGES(1)) u8 (
      .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(ir8),
      .a(a8), .b(b8), .c_in(p_cin), .sub(p_sub),
      .out_valid(ov8), .out_ready(p_ready),
      .sum(sum8), .c_out(co8), .ovf(of8)
   );

   cla_pipelined_adder #(.WIDTH(32), .STAGES(2)) u32 (
      .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(ir32),
      .a(a32), .b(b32), .c_in(p_cin), .sub(p_sub),
      .out_valid(ov32), .out_ready(p_ready),
      .sum(sum32), .c_out(co32), .ovf(of32)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      logic [W-1:0] yy;
      logic         c;
      logic [W:0]   full;
      logic [W-1:0] low;
      res_t         r;
      yy     = sb ? ~y : y;
      c      = sb ? 1'b1 : ci;
      full   = {1'b0, x} + {1'b0, yy} + (W+1)'(c);
      low    = {1'b0, x[W-2:0]} + {1'b0, yy[W-2:0]} + W'(c);
      r.sum  = full[W-1:0];
      r.cout = full[W];
      r.ovf  = low[W-1] ^ full[W];
      return r;
   endfunction

   // One clock: score an output transfer, log an input transfer, then advance.
   task automatic tick(input res_t e, output logic took);
      res_t got;
      #1;
      took = in_valid && in_ready;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_output", 32'(out_valid), 32'(0));
         end else begin
            got = exp_q.pop_front();
            chk("sum", 32'(sum), 32'(got.sum));
            chk("c_out", 32'(c_out), 32'(got.cout));
            chk("ovf", 32'(ovf), 32'(got.ovf));
         end
      end
      if (took) exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      logic took;
      int   n;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 40) begin
         tick('0, took);
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'(0));
   endtask

   // Single beat into an empty pipe: latency and result.
   task automatic single_beat(input vec_t v);
      int n;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a = v.a; b = v.b; c_in = v.cin; sub = v.sub;
      #1;
      chk("single_in_ready", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 12) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", 32'(n), 32'(4));
      chk("single_sum", 32'(sum), 32'(v.exp.sum));
      chk("single_c_out", 32'(c_out), 32'(v.exp.cout));
      chk("single_ovf", 32'(ovf), 32'(v.exp.ovf));
      @(posedge clk);
      #1;
      chk("single_out_clear", 32'(out_valid), 32'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic took;
      int   i;
      int   stall;
      logic [W-1:0] held;

      vec[0] = '{16'd217,    16'd9404,   1'b1, 1'b0, '{16'd9622,  1'b0, 1'b0}};
      vec[1] = '{16'd65535,  16'd346,    1'b1, 1'b0, '{16'd346,   1'b1, 1'b0}};
      vec[2] = '{16'h7FFF,   16'h0001,   1'b0, 1'b0, '{16'h8000,  1'b0, 1'b1}};
      vec[3] = '{16'd4582,   16'd3,      1'b0, 1'b1, '{16'd4579,  1'b1, 1'b0}};
      vec[4] = '{16'd3,      16'd4582,   1'b0, 1'b1, '{16'hEE1D,  1'b0, 1'b0}};
      vec[5] = '{16'h8000,   16'h0001,   1'b0, 1'b1, '{16'h7FFF,  1'b1, 1'b1}};
      vec[6] = '{16'hFFFF,   16'hFFFF,   1'b1, 1'b0, '{16'hFFFF,  1'b1, 1'b0}};
      vec[7] = '{16'h8000,   16'h8000,   1'b0, 1'b0, '{16'h0000,  1'b1, 1'b1}};
      vec[8] = '{16'd10,     16'd10,     1'b1, 1'b1, '{16'h0000,  1'b1, 1'b0}};
      vec[9] = '{16'h0F0F,   16'h00F1,   1'b0, 1'b0, '{16'h1000,  1'b0, 1'b0}};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
      p_valid = 1'b0; p_ready = 1'b1; p_sub = 1'b0; p_cin = 1'b0;
      a8 = '0; b8 = '0; a32 = '0; b32 = '0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_sum", 32'(sum), 32'(0));
      chk("rst_c_out", 32'(c_out), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      out_ready = 1'b1;
      @(posedge clk);
      #1;

      // Latency of a lone beat.
      single_beat(vec[0]);

      // Table stream at full throughput.
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         in_valid = 1'b1;
         a = vec[k].a; b = vec[k].b; c_in = vec[k].cin; sub = vec[k].sub;
         tick(vec[k].exp, took);
         chk("table_accept", 32'(took), 32'(1));
      end
      drain();

      // Eight back-to-back beats with a 3-cycle output stall at the first result.
      i = 0;
      stall = 0;
      held = '0;
      for (int cyc = 0; cyc < 80 && (i < 8 || exp_q.size() != 0); cyc++) begin
         in_valid = (i < 8);
         if (i < 8) begin
            a = vec[i].a; b = vec[i].b; c_in = vec[i].cin; sub = vec[i].sub;
         end
         if (out_valid && stall < 3) begin
            out_ready = 1'b0;
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            if (stall > 0) chk("stall_hold", 32'(sum), 32'(held));
            held = sum;
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         tick(vec[(i < 8) ? i : 0].exp, took);
         if (took) i++;
      end
      chk("stall_cycles", 32'(stall), 32'(3));
      chk("stall_all_sent", 32'(i), 32'(8));
      drain();

      // Reset with three beats in flight.
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_valid = 1'b1;
         a = vec[k+3].a; b = vec[k+3].b; c_in = vec[k+3].cin; sub = vec[k+3].sub;
         tick(vec[k+3].exp, took);
      end
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      exp_q.delete();
      for (int k = 0; k < 6; k++) begin
         chk("midrst_no_stale", 32'(out_valid), 32'(0));
         tick('0, took);
      end
      single_beat(vec[4]);

      // Other parametrisations: 8-bit single stage, 32-bit two stages.
      p_valid = 1'b1; p_sub = 1'b0; p_cin = 1'b0;
      a8 = 8'hFF; b8 = 8'h01;
      a32 = 32'h7FFF_FFFF; b32 = 32'h0000_0001;
      @(posedge clk);
      #1;
      p_valid = 1'b0;
      chk("w8_out_valid", 32'(ov8), 32'(1));
      chk("w8_sum", 32'(sum8), 32'(8'h00));
      chk("w8_c_out", 32'(co8), 32'(1));
      chk("w8_ovf", 32'(of8), 32'(0));
      chk("w32_not_yet", 32'(ov32), 32'(0));
      @(posedge clk);
      #1;
      chk("w8_out_clear", 32'(ov8), 32'(0));
      chk("w32_out_valid", 32'(ov32), 32'(1));
      chk("w32_sum", sum32, 32'h8000_0000);
      chk("w32_c_out", 32'(co32), 32'(0));
      chk("w32_ovf", 32'(of32), 32'(1));
      p_valid = 1'b1; p_sub = 1'b1;
      a32 = 32'd5; b32 = 32'd7;
      @(posedge clk);
      #1;
      p_valid = 1'b0;
      @(posedge clk);
      #1;
      chk("w32_sub_valid", 32'(ov32), 32'(1));
      chk("w32_sub_sum", sum32, 32'hFFFF_FFFE);
      chk("w32_sub_c_out", 32'(co32), 32'(0));
      chk("w32_sub_ovf", 32'(of32), 32'(0));

      // Random traffic with random valid/ready against the reference model.
      for (int cyc = 0; cyc < 10000; cyc++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         a    = W'($urandom);
         b    = W'($urandom);
         c_in = 1'($urandom_range(0, 1));
         sub  = 1'($urandom_range(0, 1));
         tick(model(a, b, c_in, sub), took);
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
